parity_checker_stream: RTL and testbench
========================================

// Module: parity_checker_stream
//
// PURPOSE
//   Parametrised, pipelined successor to the 4-bit combinational parity checker.
//   Checks a stream of DATA_W-bit words, each with a received parity bit, under even or odd mode.
//   Uses valid/ready handshakes on both sides and flags per-word and per-frame errors.
//   Keeps a saturating error counter and a sticky error flag.
//   Sits between a receiver front-end and downstream consumers or status registers.
//
// PARAMETERS
//   DATA_W  8  width of checked data word (>=1)
//   CNT_W   8  width of error counter (>=1)
//
// PORTS
//   clk            in   1       rising-edge clock
//   rst_n          in   1       asynchronous active-low reset
//   odd_mode       in   1       0 = even parity, 1 = odd parity; sampled with each accepted word
//   in_valid       in   1       input word valid
//   in_ready       out  1       block can accept a word
//   in_data        in   DATA_W  data word
//   in_parity      in   1       received parity bit
//   in_last        in   1       last word of frame
//   out_valid      out  1       result valid
//   out_ready      in   1       downstream accepts result
//   out_err        out  1       parity mismatch on this word
//   out_last       out  1       registered copy of in_last
//   out_frame_err  out  1       on last word only: any word error in the frame (this word included)
//   err_cnt        out  CNT_W   saturating count of word errors
//   err_sticky     out  1       set on any word error; cleared only by clr
//   clr            in   1       synchronous clear of err_cnt and err_sticky
//
// BEHAVIOUR
//   - Reset: out_valid, out_err, out_last, out_frame_err, err_cnt, err_sticky and frame_acc all 0.
//     in_ready is 1 after reset. Reset mid-frame discards the partial frame.
//   - Handshakes:
//     - Accept when in_valid & in_ready.
//     - Transfer out when out_valid & out_ready.
//     - in_ready = !out_valid | out_ready, so the output stage is a single register stage.
//     - Latency is 1 cycle; full throughput with out_ready held at 1.
//     - Output fields stay stable while out_valid & !out_ready.
//   - Word check: exp = ^in_data ^ odd_mode; word_err = (in_parity != exp).
//     - Even mode: total ones over data and parity is even.
//     - Odd mode: total ones over data and parity is odd.
//   - Frame accumulation:
//     - frame_acc <= in_last ? 0 : (frame_acc | word_err) on each accepted word.
//     - out_frame_err = frame_acc | word_err, registered only when in_last; otherwise 0.
//     - A word with in_last=1 and no prior word is a 1-word frame.
//   - Error counter:
//     - err_cnt increments on an accepted word with word_err=1.
//     - It saturates at 2^CNT_W-1 and does not wrap.
//     - The counter and err_sticky update at acceptance, not at the output transfer.
//   - clr has priority over a same-cycle error. In that cycle err_cnt and err_sticky go to 0.
//     The error is not counted but is still reported on out_err.
//   - Changing odd_mode mid-frame is legal; each word is checked with its own sampled mode.
//   - No state machine beyond the output-valid register and frame_acc.
//
// STRUCTURE
//   - Package parity_pkg holds:
//     - localparam MODE_EVEN=1'b0, MODE_ODD=1'b1;
//     - function parity_of(logic [DATA_W-1:0]) (parametrised via a class or a macro);
//     - a typedef struct for the result {err, last, frame_err}.
//   - One sub-module, sat_counter (CNT_W, inc, clr, cnt), which is reused by other status blocks.
//   - Everything else is inline in parity_checker_stream.
//
// TESTING (DATA_W=8, CNT_W=4)
//   1. Even mode, data=8'hA5, parity=0 -> out_err=0 one cycle later.
//      Same data with parity=1 -> out_err=1, err_cnt=1, err_sticky=1.
//   2. Odd mode, data=8'h01, parity=0 -> out_err=0; parity=1 -> out_err=1.
//      Sweep all 256 data values in both modes against a reference model.
//   3. Frame of 3 words (err on word 2 only, last on word 3) -> out_frame_err=1 on word 3 only.
//      Next clean 3-word frame -> out_frame_err=0.
//   4. Hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 after the first word.
//      The output holds stable and no word is lost or duplicated. Then random ready/valid for 1000 words.
//   5. Inject 20 errors -> err_cnt saturates at 15.
//      Assert clr in the same cycle as an error word -> err_cnt=0, err_sticky=0, out_err=1.
//   6. Assert rst_n low mid-frame (after 1 erroneous word) -> all outputs 0.
//      The next 1-word clean frame gives out_frame_err=0.

Source files
------------

// File: rtl/parity_pkg.sv
// Shared types and helpers for the streaming parity checker and related status blocks.
// parity_of takes a fixed-width argument; callers zero-extend, which leaves parity unchanged.
package parity_pkg;

    localparam logic MODE_EVEN = 1'b0;
    localparam logic MODE_ODD  = 1'b1;

    // Widest data word parity_of can cover.
    localparam int PARITY_MAX_W = 256;

    typedef struct packed {
        logic err;
        logic last;
        logic frame_err;
    } result_t;

    function automatic logic parity_of(input logic [PARITY_MAX_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// clr wins over a same-cycle increment.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/parity_checker_stream.sv
// Streaming parity checker: one-register output stage with valid/ready on both sides,
// per-word and per-frame error flags, saturating error count and sticky error flag.
module parity_checker_stream
    import parity_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              odd_mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_parity,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_err,
    output logic              out_last,
    output logic              out_frame_err,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              err_sticky,
    input  logic              clr
);

    logic    w_accept;
    logic    w_exp;
    logic    w_word_err;
    result_t w_res;

    logic    r_out_valid;
    result_t r_res;
    logic    r_frame_acc;
    logic    r_sticky;

    // The output register can take a new word whenever it is empty or draining this cycle.
    assign in_ready   = !r_out_valid | out_ready;
    assign w_accept   = in_valid & in_ready;
    assign w_exp      = parity_of(PARITY_MAX_W'(in_data)) ^ odd_mode;
    assign w_word_err = (in_parity != w_exp);

    always_comb begin
        w_res           = '0;
        w_res.err       = w_word_err;
        w_res.last      = in_last;
        w_res.frame_err = in_last & (r_frame_acc | w_word_err);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_res       <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_res       <= w_res;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Errors seen so far in the current frame; the last word closes the frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_acc <= 1'b0;
        end else if (w_accept) begin
            r_frame_acc <= in_last ? 1'b0 : (r_frame_acc | w_word_err);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky <= 1'b0;
        end else if (clr) begin
            r_sticky <= 1'b0;
        end else if (w_accept && w_word_err) begin
            r_sticky <= 1'b1;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_accept & w_word_err),
        .clr   (clr),
        .cnt   (err_cnt)
    );

    assign out_valid     = r_out_valid;
    assign out_err       = r_res.err;
    assign out_last      = r_res.last;
    assign out_frame_err = r_res.frame_err;
    assign err_sticky    = r_sticky;

endmodule

// File: tb/tb_parity_checker_stream.sv
// Randomised and directed bench for parity_checker_stream with a scoreboard model.
module tb_parity_checker_stream;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              odd_mode;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_parity;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic              out_err;
    logic              out_last;
    logic              out_frame_err;
    logic [CNT_W-1:0]  err_cnt;
    logic              err_sticky;
    logic              clr;

    int n_chk = 0;
    int n_err = 0;
    int rdy_mode = 0; // 0: ready high, 1: ready low, 2: random

    parity_checker_stream #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .odd_mode(odd_mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_parity(in_parity), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_err(out_err),
        .out_last(out_last), .out_frame_err(out_frame_err),
        .err_cnt(err_cnt), .err_sticky(err_sticky), .clr(clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Reference model: word error from popcount, frame error from "any error since frame start".
    logic [2:0] sb[$];
    int   m_cnt = 0;
    logic m_sticky = 1'b0;
    logic m_frame_any = 1'b0;
    logic [2:0] hold;
    logic have_hold = 1'b0;

    always @(negedge clk) begin
        logic e;
        logic [2:0] exp_r;
        if (!rst_n) begin
            sb.delete();
            m_cnt = 0;
            m_sticky = 1'b0;
            m_frame_any = 1'b0;
            have_hold = 1'b0;
        end else begin
            chk("err_cnt", 32'(err_cnt), m_cnt);
            chk("err_sticky", 32'(err_sticky), 32'(m_sticky));
            if (out_valid) begin
                if (have_hold)
                    chk("hold_stable", 32'({out_err, out_last, out_frame_err}), 32'(hold));
                if (out_ready) begin
                    if (sb.size() == 0) chk("sb_underflow", 1, 0);
                    else begin
                        exp_r = sb.pop_front();
                        chk("out_err", 32'(out_err), 32'(exp_r[2]));
                        chk("out_last", 32'(out_last), 32'(exp_r[1]));
                        chk("out_frame_err", 32'(out_frame_err), 32'(exp_r[0]));
                    end
                    have_hold = 1'b0;
                end else begin
                    hold = {out_err, out_last, out_frame_err};
                    have_hold = 1'b1;
                end
            end
            e = 1'b0;
            if (in_valid && in_ready) begin
                e = 1'(((($countones(in_data) + int'(in_parity)) % 2) != int'(odd_mode)));
                sb.push_back({e, in_last, in_last & (m_frame_any | e)});
                m_frame_any = in_last ? 1'b0 : (m_frame_any | e);
            end
            if (clr) begin
                m_cnt = 0;
                m_sticky = 1'b0;
            end else if (e) begin
                if (m_cnt < CNT_MAX) m_cnt++;
                m_sticky = 1'b1;
            end
        end
    end

    task automatic idle();
        in_valid = 1'b0;
        clr = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Present one word and return #1 after the edge that accepts it.
    task automatic send(input logic [DATA_W-1:0] d, input logic p, input logic l,
                        input logic m, input logic c);
        bit done = 0;
        in_valid = 1'b1; in_data = d; in_parity = p; in_last = l; odd_mode = m; clr = c;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
        end
        if (!done) chk("send_timeout", 0, 1);
        clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_parity = 1'b0;
        in_last = 1'b0; odd_mode = 1'b0; clr = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_fields", 32'({out_err, out_last, out_frame_err}), 0);
        chk("rst_cnt", 32'(err_cnt), 0);
        chk("rst_sticky", 32'(err_sticky), 0);
        rst_n = 1'b1;
        idle();

        // 1: even mode
        send(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t1_err0", 32'(out_err), 0);
        send(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("t1_err1", 32'(out_err), 1);
        idle();
        chk("t1_cnt", 32'(err_cnt), 1);
        chk("t1_sticky", 32'(err_sticky), 1);

        // 2: odd mode and full sweep
        send(8'h01, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("t2_err0", 32'(out_err), 0);
        send(8'h01, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("t2_err1", 32'(out_err), 1);
        for (int m = 0; m < 2; m++)
            for (int d = 0; d < 256; d++)
                send(8'(d), 1'($urandom_range(0, 1)), 1'b1, 1'(m), 1'b0);
        idle();

        // 3: frames
        send(8'h03, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t3_w1_ferr", 32'(out_frame_err), 0);
        send(8'h07, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t3_w2_err", 32'(out_err), 1);
        chk("t3_w2_ferr", 32'(out_frame_err), 0);
        send(8'h0F, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t3_w3_ferr", 32'(out_frame_err), 1);
        send(8'h03, 1'b0, 1'b0, 1'b0, 1'b0);
        send(8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
        send(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t3_clean_ferr", 32'(out_frame_err), 0);
        chk("t3_clean_last", 32'(out_last), 1);
        idle();

        // 4: backpressure then random handshakes
        rdy_mode = 1;
        idle();
        send(8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b1; in_data = 8'h22; in_parity = 1'b0; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_in_ready", 32'(in_ready), 0);
            chk("t4_out_valid", 32'(out_valid), 1);
        end
        rdy_mode = 0;
        @(posedge clk);
        #1;
        send(8'h22, 1'b0, 1'b1, 1'b0, 1'b0);
        idle();
        rdy_mode = 2;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) idle();
            send(8'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0));
        end
        idle();
        rdy_mode = 0;
        repeat (3) idle();

        // 5: saturation and clr priority
        for (int i = 0; i < 20; i++) send(8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        idle();
        chk("t5_sat", 32'(err_cnt), CNT_MAX);
        send(8'h00, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("t5_clr_cnt", 32'(err_cnt), 0);
        chk("t5_clr_sticky", 32'(err_sticky), 0);
        chk("t5_clr_out_err", 32'(out_err), 1);
        idle();

        // 6: reset mid-frame
        send(8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        rst_n = 1'b0;
        #1;
        chk("t6_valid", 32'(out_valid), 0);
        chk("t6_fields", 32'({out_err, out_last, out_frame_err}), 0);
        chk("t6_cnt", 32'(err_cnt), 0);
        chk("t6_sticky", 32'(err_sticky), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle();
        send(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t6_ferr", 32'(out_frame_err), 0);
        chk("t6_err", 32'(out_err), 0);
        repeat (3) idle();
        chk("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
